// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiply is shift-add and divide is restoring; each takes one operand bit
// per cycle for WIDTH cycles in CALC. After that, a single FIX cycle applies
// sign correction and writes the result to hi/lo.
//
// Handshake: start is sampled only in IDLE. An accepted mul/div raises busy
// from the next cycle through FIX. The cycle after FIX, done pulses once and
// hi/lo hold the result. A new start may be presented in that done cycle.
// flush squashes an in-flight op without touching hi/lo.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_main;  // negate product / quotient
  logic               neg_rem;   // negate remainder (dividend was negative)
  logic               div_zero;
  logic [WIDTH-1:0]   opd;       // multiplicand (mul) or divisor (div), magnitude
  logic [2*WIDTH-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}

  logic               idle_req;
  logic               accept;
  logic               mv_hi;
  logic               mv_lo;
  logic               last;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // A flush arriving alongside start wins, so nothing is taken from IDLE.
  assign idle_req = (state == S_IDLE) && start && !flush;
  assign accept   = idle_req && !op[2];
  assign mv_hi    = idle_req && (op == 3'b100);
  assign mv_lo    = idle_req && (op == 3'b101);
  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign busy     = (state == S_CALC) || (state == S_FIX);

  // Signed ops (op[0]=1) work on magnitudes; signs are restored in FIX.
  assign a_abs = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_abs = (op[0] && b[WIDTH-1]) ? -b : b;

  // One shift-add step: optionally add the multiplicand into the upper half,
  // then shift the whole accumulator right, keeping the carry.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring-division step. A zero divisor always "fits", which makes
  // the quotient all ones and leaves the dividend as the remainder.
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, opd};
  assign q_bit    = ~rem_diff[WIDTH];
  assign div_next = {(q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};

  // Sign correction applied while in FIX.
  assign prod_fix = neg_main ? -acc : acc;
  assign quo_fix  = div_zero ? {WIDTH{1'b1}} : (neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_CALC;
      S_CALC: begin
        if (flush)     state_nxt = S_IDLE;
        else if (last) state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath, result registers and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opd      <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_FIX) && !flush;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            is_div   <= op[1];
            neg_main <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= op[0] && op[1] && a[WIDTH-1];
            div_zero <= op[1] && (b == '0);
            opd      <= op[1] ? b_abs : a_abs;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
          end
          if (mv_hi) hi <= a;
          if (mv_lo) lo <= a;
        end
        S_CALC: begin
          if (!flush) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!flush) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit (WIDTH=32): directed cases plus a randomized run,
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  // clock / reset
  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      3'd0: res = {32'd0, x} * {32'd0, y};
      3'd1: res = sx * sy;
      3'd2: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      3'd3: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issue a mul/div at a negedge and follow it to its done cycle.
  task automatic mul_div(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] e;
    int n;
    bit got_done;
    bit busy_ok;
    exp_q.push_back(model_result(o, x, y));
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    got_done = 1'b0; busy_ok = 1'b1; n = 1;
    while (n <= 200) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check_val("busy_window", busy_ok, 1);
    check_val("latency", n, W + 2);
    check_val("busy_at_done", busy, 0);
    e = exp_q.pop_front();
    if (got_done) begin
      check_val("hi", hi, e[63:32]);
      check_val("lo", lo, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  // MTHI/MTLO or no-op from IDLE.
  task automatic move(input logic [2:0] o, input logic [W-1:0] x);
    op = o; a = x; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (o == 3'd4) m_hi = x;
    else if (o == 3'd5) m_lo = x;
    check_val("move_hi", hi, m_hi);
    check_val("move_lo", lo, m_lo);
    check_val("move_done", done, 0);
    check_val("move_busy", busy, 0);
  endtask

  task automatic flush_test();
    bit saw_done;
    op = 3'd0; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    for (int n = 2; n <= 21; n++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (n == 10) begin op = 3'd5; a = $urandom; start = 1'b1; end
      if (n == 11) start = 1'b0;
      if (n == 20) flush = 1'b1;
      if (n == 21) flush = 1'b0;
    end
    check_val("flush_busy", busy, 0);
    check_val("flush_hi", hi, m_hi);
    check_val("flush_lo", lo, m_lo);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_val("flush_no_done", saw_done, 0);
    check_val("flush_hi_late", hi, m_hi);
    check_val("flush_lo_late", lo, m_lo);
  endtask

  initial begin
    logic [2:0] o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    bit saw_done;

    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_hi", hi, 0);
    check_val("rst_lo", lo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vectors
    mul_div(3'd0, 32'd7, 32'd6);
    check_val("multu_42", lo, 32'h2A);
    mul_div(3'd1, 32'hFFFF_FFFD, 32'd5);
    check_val("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check_val("mult_neg_lo", lo, 32'hFFFF_FFF1);
    mul_div(3'd3, 32'hFFFF_FFF9, 32'd2);
    check_val("div_neg_lo", lo, 32'hFFFF_FFFD);
    check_val("div_neg_hi", hi, 32'hFFFF_FFFF);
    mul_div(3'd2, 32'h1234_5678, 32'd0);
    check_val("divz_hi", hi, 32'h1234_5678);
    check_val("divz_lo", lo, 32'hFFFF_FFFF);
    mul_div(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check_val("divmin_lo", lo, 32'h8000_0000);
    check_val("divmin_hi", hi, 32'h0);
    mul_div(3'd3, 32'hFFFF_FFF9, 32'd0);
    move(3'd4, 32'hCAFE_BABE);
    move(3'd5, 32'h1357_9BDF);

    flush_test();

    // back-to-back: second start presented in the done cycle
    mul_div(3'd0, $urandom, $urandom);
    mul_div(3'd0, $urandom, $urandom);

    // flush together with start in IDLE: nothing accepted
    op = 3'd4; a = $urandom; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 3'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_val("idle_flush_hi", hi, m_hi);
    check_val("idle_flush_busy", busy, 0);

    // reset in the middle of a divide
    op = 3'd3; a = $urandom; b = $urandom_range(1, 1000); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 2; n <= 15; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_hi", hi, 0);
    check_val("mid_rst_lo", lo, 0);
    check_val("mid_rst_done", done, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check_val("post_rst_quiet", saw_done, 0);
    mul_div(3'd0, 32'd3, 32'd3);
    check_val("post_rst_lo9", lo, 32'd9);

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      if (o < 3'd4) mul_div(o, x, y);
      else move(o, x);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
